// File: rtl/ysyx_22051086_ifu.sv
// ysyx_22051086_ifu: instruction fetch stage, single outstanding request.
// Ports: clk/rst, imem req/resp handshakes, br_bus/exc redirect, if_to_id bundle.
module ysyx_22051086_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [95:0] if_to_id_bus,
    input  logic [65:0] br_bus,
    input  logic        exc_redirect,
    input  logic [63:0] exc_target,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [63:0] inst_req_addr,
    input  logic        inst_resp_valid,
    output logic        inst_resp_ready,
    input  logic [31:0] inst_resp_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        discard_q, discard_d;

    logic        br_stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        redir;
    logic [63:0] redir_tgt;
    logic        req_hs;
    logic        resp_hs;
    logic        out_fire;

    assign br_stall  = br_bus[65];
    assign br_taken  = br_bus[64];
    assign br_target = br_bus[63:0];

    assign redir     = exc_redirect || (br_taken && id_allowin);
    assign redir_tgt = exc_redirect ? exc_target : br_target;

    assign inst_req_valid  = (state_q == REQ) && !br_stall;
    assign inst_req_addr   = fetch_pc_q;
    assign inst_resp_ready = (state_q == WAIT) &&
                             (!out_valid_q || (id_allowin && !redir));

    assign req_hs   = inst_req_valid && inst_req_ready;
    assign resp_hs  = inst_resp_valid && inst_resp_ready;
    assign out_fire = if_to_id_valid && id_allowin;

    assign if_to_id_valid = out_valid_q && !redir;
    assign if_to_id_bus   = {out_pc_q, out_inst_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        discard_d   = discard_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (req_hs) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (resp_hs) begin
                    state_d = REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (!redir) begin
                        // fetch_pc already advanced past the
                        // request, so it sits 4 ahead of it.
                        out_valid_d = 1'b1;
                        out_pc_d    = fetch_pc_q - 64'd4;
                        out_inst_d  = inst_resp_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A response consumed this cycle leaves nothing to squash;
        // one still in flight, or just requested, must be dropped.
        if (redir) begin
            fetch_pc_d  = redir_tgt;
            out_valid_d = 1'b0;
            if (((state_q == WAIT) && !resp_hs) || req_hs) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 64'd0;
            out_inst_q  <= 32'd0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            discard_q   <= discard_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22051086_ifu.sv
// tb_ysyx_22051086_ifu: directed bench for the fetch stage.
// A 1-cycle memory responder returns addr[31:0] + 0x13 as the word.
module tb_ysyx_22051086_ifu;

    logic        clk;
    logic        rst;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [95:0] if_to_id_bus;
    logic [65:0] br_bus;
    logic        br_stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        exc_redirect;
    logic [63:0] exc_target;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [63:0] inst_req_addr;
    logic        inst_resp_valid;
    logic        inst_resp_ready;
    logic [31:0] inst_resp_data;

    logic        mem_en;
    logic        mem_pend;
    logic [63:0] mem_addr;

    int checks;
    int failures;

    assign br_bus          = {br_stall, br_taken, br_target};
    assign inst_resp_valid = mem_pend && mem_en;
    assign inst_resp_data  = mem_addr[31:0] + 32'h13;

    ysyx_22051086_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .id_allowin      (id_allowin),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_bus    (if_to_id_bus),
        .br_bus          (br_bus),
        .exc_redirect    (exc_redirect),
        .exc_target      (exc_target),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_ready (inst_resp_ready),
        .inst_resp_data  (inst_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mem_pend <= 1'b0;
            mem_addr <= 64'd0;
        end else begin
            if (inst_resp_valid && inst_resp_ready) mem_pend <= 1'b0;
            if (inst_req_valid && inst_req_ready) begin
                mem_pend <= 1'b1;
                mem_addr <= inst_req_addr;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        id_allowin   = 1'b1;
        br_stall     = 1'b0;
        br_taken     = 1'b0;
        br_target    = 64'd0;
        exc_redirect = 1'b0;
        exc_target   = 64'd0;
        inst_req_ready = 1'b1;
        mem_en       = 1'b1;

        nxt(); nxt(); #1;
        chk("rst_req_valid", 96'(inst_req_valid), 96'd0);
        chk("rst_resp_ready", 96'(inst_resp_ready), 96'd0);
        chk("rst_if_valid", 96'(if_to_id_valid), 96'd0);
        chk("rst_bus", if_to_id_bus, 96'd0);

        nxt(); rst = 1'b0; #1;
        chk("idle_req_valid", 96'(inst_req_valid), 96'd0);

        nxt(); #1;
        chk("a_req_valid", 96'(inst_req_valid), 96'd1);
        chk("a_req_addr", 96'(inst_req_addr), 96'h8000_0000);

        nxt(); #1;
        chk("b_req_valid", 96'(inst_req_valid), 96'd0);
        chk("b_resp_ready", 96'(inst_resp_ready), 96'd1);
        chk("b_if_valid", 96'(if_to_id_valid), 96'd0);

        nxt(); #1;
        chk("c_req_addr", 96'(inst_req_addr), 96'h8000_0004);
        chk("c_if_valid", 96'(if_to_id_valid), 96'd1);
        chk("c_bus", if_to_id_bus, {64'h8000_0000, 32'h8000_0013});

        nxt(); #1;
        chk("d_if_valid", 96'(if_to_id_valid), 96'd0);

        nxt(); id_allowin = 1'b0; #1;
        chk("e_bus", if_to_id_bus, {64'h8000_0004, 32'h8000_0017});
        chk("e_req_addr", 96'(inst_req_addr), 96'h8000_0008);

        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            chk("bp_if_valid", 96'(if_to_id_valid), 96'd1);
            chk("bp_bus", if_to_id_bus, {64'h8000_0004, 32'h8000_0017});
            chk("bp_resp_ready", 96'(inst_resp_ready), 96'd0);
        end

        nxt(); id_allowin = 1'b1; #1;
        chk("j_resp_ready", 96'(inst_resp_ready), 96'd1);
        chk("j_bus", if_to_id_bus, {64'h8000_0004, 32'h8000_0017});

        nxt(); id_allowin = 1'b0; #1;
        chk("k_bus", if_to_id_bus, {64'h8000_0008, 32'h8000_001b});
        chk("k_if_valid", 96'(if_to_id_valid), 96'd1);
        chk("k_req_addr", 96'(inst_req_addr), 96'h8000_000c);

        nxt();
        id_allowin = 1'b1;
        br_taken   = 1'b1;
        br_target  = 64'h8000_0100;
        mem_en     = 1'b0;
        #1;
        chk("br_mask_if_valid", 96'(if_to_id_valid), 96'd0);
        chk("br_resp_ready", 96'(inst_resp_ready), 96'd0);

        nxt(); br_taken = 1'b0; mem_en = 1'b1; #1;
        chk("m_if_valid", 96'(if_to_id_valid), 96'd0);
        chk("m_resp_ready", 96'(inst_resp_ready), 96'd1);

        nxt(); #1;
        chk("n_req_valid", 96'(inst_req_valid), 96'd1);
        chk("n_req_addr", 96'(inst_req_addr), 96'h8000_0100);
        chk("n_if_valid", 96'(if_to_id_valid), 96'd0);

        nxt(); #1;
        chk("o_resp_ready", 96'(inst_resp_ready), 96'd1);

        nxt();
        chk("p_bus", if_to_id_bus, {64'h8000_0100, 32'h8000_0113});
        chk("p_if_valid", 96'(if_to_id_valid), 96'd1);
        exc_redirect = 1'b1;
        exc_target   = 64'h8000_0400;
        br_taken     = 1'b1;
        br_target    = 64'h8000_0100;
        #1;
        chk("exc_mask_if_valid", 96'(if_to_id_valid), 96'd0);

        nxt(); exc_redirect = 1'b0; br_taken = 1'b0; #1;
        chk("q_if_valid", 96'(if_to_id_valid), 96'd0);
        chk("q_resp_ready", 96'(inst_resp_ready), 96'd1);

        nxt(); #1;
        chk("exc_req_valid", 96'(inst_req_valid), 96'd1);
        chk("exc_req_addr", 96'(inst_req_addr), 96'h8000_0400);
        br_stall = 1'b1; #1;
        chk("stall0_req_valid", 96'(inst_req_valid), 96'd0);

        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("stall_req_valid", 96'(inst_req_valid), 96'd0);
            chk("stall_req_addr", 96'(inst_req_addr), 96'h8000_0400);
        end

        nxt(); br_stall = 1'b0; #1;
        chk("u_req_valid", 96'(inst_req_valid), 96'd1);
        chk("u_req_addr", 96'(inst_req_addr), 96'h8000_0400);

        nxt(); rst = 1'b1; #1;
        chk("v_resp_ready", 96'(inst_resp_ready), 96'd1);

        nxt(); #1;
        chk("w_req_valid", 96'(inst_req_valid), 96'd0);
        chk("w_resp_ready", 96'(inst_resp_ready), 96'd0);
        chk("w_if_valid", 96'(if_to_id_valid), 96'd0);
        chk("w_bus", if_to_id_bus, 96'd0);

        nxt(); rst = 1'b0; #1;
        chk("x_req_valid", 96'(inst_req_valid), 96'd0);

        nxt(); #1;
        chk("y_req_valid", 96'(inst_req_valid), 96'd1);
        chk("y_req_addr", 96'(inst_req_addr), 96'h8000_0000);

        nxt(); nxt(); #1;
        chk("aa_bus", if_to_id_bus, {64'h8000_0000, 32'h8000_0013});
        chk("aa_if_valid", 96'(if_to_id_valid), 96'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
